// File: rtl/io_fl_pkg.sv
// Shared definitions for the floating-point I/O controller: word width
// helper and the two-state encoding used by every buffer slot.
package io_fl_pkg;

   // Slot occupancy. Input slots call the occupied state FULL, output
   // slots call it VALID; both share the same encoding.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   localparam slot_state_e SLOT_VALID = SLOT_FULL;

   // Processor word width: sign + exponent + mantissa.
   function automatic int fl_w(input int nbmant, input int nbexpo);
      return nbmant + nbexpo + 1;
   endfunction

endpackage

// File: rtl/io_slot_fl.sv
// Single-entry W-bit buffer with load/drain strobes, a full flag and an
// overwrite-detect output (load arriving while full and not draining).
module io_slot_fl
   import io_fl_pkg::*;
#(
   parameter int W = 23
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         drain,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         ovw
);

   slot_state_e  state_q;
   slot_state_e  state_d;
   logic [W-1:0] data_q;

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state_q <= SLOT_EMPTY;
      else     state_q <= state_d;
   end

   // Next state: a load (re)fills the slot and wins over a drain, so a
   // simultaneous drain + load leaves the slot occupied with the new word.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned
      // and no latch is inferred.
      state_d = state_q;
      if (load)       state_d = SLOT_FULL;
      else if (drain) state_d = SLOT_EMPTY;
   end

   // Data register: captures the word on every load.
   // NOTE: the data register is reset deliberately; a stale word read from
   // an empty slot must be 0 after reset, not X.
   always_ff @(posedge clk) begin
      if (rst)       data_q <= '0;
      else if (load) data_q <= din;
   end

   // Outputs: occupancy flag and overwrite detection.
   always_comb begin
      full = (state_q == SLOT_FULL);
      ovw  = load & (state_q == SLOT_FULL) & ~drain;
   end

   assign dout = data_q;

endmodule

// File: rtl/io_ctrl_fl.sv
// Buffered I/O controller for proc_fl. One single-word buffer per input
// address and per output address; turns the processor's req_in/out_en
// strobes into per-slot valid/ready handshakes, reports underrun, overrun
// and bad-address events, and raises itr while masked input data waits.
module io_ctrl_fl
   import io_fl_pkg::*;
#(
   parameter  int                NBMANT = 16,
   parameter  int                NBEXPO = 6,
   parameter  int                NUIOIN = 2,
   parameter  int                NUIOOU = 2,
   parameter  logic [NUIOIN-1:0] ITRMSK = '1,
   localparam int                W      = fl_w(NBMANT, NBEXPO),
   localparam int                AIW    = $clog2(NUIOIN),
   localparam int                AOW    = $clog2(NUIOOU)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUIOIN*W-1:0]  src_data,
   input  logic [NUIOIN-1:0]    src_valid,
   output logic [NUIOIN-1:0]    src_ready,
   output logic [W-1:0]         io_in,
   input  logic [AIW-1:0]       addr_in,
   input  logic                 req_in,
   input  logic [W-1:0]         io_out,
   input  logic [AOW-1:0]       addr_out,
   input  logic                 out_en,
   output logic [NUIOOU*W-1:0]  snk_data,
   output logic [NUIOOU-1:0]    snk_valid,
   input  logic [NUIOOU-1:0]    snk_ready,
   output logic                 itr,
   output logic                 in_underrun,
   output logic                 out_overrun,
   output logic                 addr_err
);

   logic [W-1:0]      in_dout  [NUIOIN];
   logic [NUIOIN-1:0] in_full;
   logic [NUIOIN-1:0] in_load;
   logic [NUIOIN-1:0] in_drain;
   logic [NUIOIN-1:0] in_ovw;

   logic [W-1:0]      out_dout [NUIOOU];
   logic [NUIOOU-1:0] out_full;
   logic [NUIOOU-1:0] out_load;
   logic [NUIOOU-1:0] out_drain;
   logic [NUIOOU-1:0] out_ovw;

   logic in_addr_ok;
   logic out_addr_ok;
   logic rd_empty;

   logic itr_q;
   logic underrun_q;
   logic overrun_q;
   logic addr_err_q;

   // Input loads are gated by ready, so a load never meets a read of the
   // same slot; the input-side overwrite flag is structurally zero.
   logic unused_in_ovw;
   assign unused_in_ovw = |in_ovw;

   // Address range decode for both processor ports.
   always_comb begin
      in_addr_ok  = (int'(addr_in)  < NUIOIN);
      out_addr_ok = (int'(addr_out) < NUIOOU);
   end

   // Input slots: producer fills an empty slot, processor read empties it.
   for (genvar i = 0; i < NUIOIN; i++) begin : g_in
      assign in_load[i]  = src_valid[i] & ~in_full[i];
      assign in_drain[i] = req_in & (int'(addr_in) == i) & in_full[i];

      io_slot_fl #(.W(W)) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (in_load[i]),
         .drain (in_drain[i]),
         .din   (src_data[i*W +: W]),
         .dout  (in_dout[i]),
         .full  (in_full[i]),
         .ovw   (in_ovw[i])
      );
   end

   // Output slots: processor write fills, consumer handshake drains.
   for (genvar j = 0; j < NUIOOU; j++) begin : g_out
      assign out_load[j]  = out_en & out_addr_ok & (int'(addr_out) == j);
      assign out_drain[j] = out_full[j] & snk_ready[j];

      io_slot_fl #(.W(W)) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (out_load[j]),
         .drain (out_drain[j]),
         .din   (io_out),
         .dout  (out_dout[j]),
         .full  (out_full[j]),
         .ovw   (out_ovw[j])
      );

      assign snk_data[j*W +: W] = out_dout[j];
   end

   // Read mux: io_in follows addr_in regardless of req_in; out-of-range
   // addresses read as 0. Also flags a read of an empty in-range slot.
   always_comb begin
      io_in    = '0;
      rd_empty = 1'b0;
      for (int i = 0; i < NUIOIN; i++) begin
         if (int'(addr_in) == i) begin
            io_in    = in_dout[i];
            rd_empty = ~in_full[i];
         end
      end
   end

   // Registered interrupt level and one-cycle event pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         itr_q      <= 1'b0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         itr_q      <= |(in_full & ITRMSK);
         underrun_q <= req_in & in_addr_ok & rd_empty;
         overrun_q  <= |out_ovw;
         addr_err_q <= (req_in & ~in_addr_ok) | (out_en & ~out_addr_ok);
      end
   end

   assign src_ready   = ~in_full;
   assign snk_valid   = out_full;
   assign itr         = itr_q;
   assign in_underrun = underrun_q;
   assign out_overrun = overrun_q;
   assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_io_ctrl_fl.sv
// Scenario bench for io_ctrl_fl with three input and three output slots so
// that out-of-range addresses are reachable. Inputs change 1 ns after the
// rising edge; outputs are sampled 2 ns after it.
module tb_io_ctrl_fl;

   localparam int W = 23;

   logic           clk = 1'b0;
   logic           rst;
   logic [3*W-1:0] src_data;
   logic [2:0]     src_valid;
   logic [2:0]     src_ready;
   logic [W-1:0]   io_in;
   logic [1:0]     addr_in;
   logic           req_in;
   logic [W-1:0]   io_out;
   logic [1:0]     addr_out;
   logic           out_en;
   logic [3*W-1:0] snk_data;
   logic [2:0]     snk_valid;
   logic [2:0]     snk_ready;
   logic           itr;
   logic           in_underrun;
   logic           out_overrun;
   logic           addr_err;

   int checks = 0;
   int errors = 0;

   // Scoreboards: expected io_in words for reads, expected consumer words
   // per output slot (oldest first).
   logic [W-1:0] rd_q[$];
   logic [W-1:0] snk_q0[$];
   logic [W-1:0] snk_q1[$];

   always #5 clk = ~clk;

   io_ctrl_fl #(
      .NBMANT (16),
      .NBEXPO (6),
      .NUIOIN (3),
      .NUIOOU (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .src_data    (src_data),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .io_in       (io_in),
      .addr_in     (addr_in),
      .req_in      (req_in),
      .io_out      (io_out),
      .addr_out    (addr_out),
      .out_en      (out_en),
      .snk_data    (snk_data),
      .snk_valid   (snk_valid),
      .snk_ready   (snk_ready),
      .itr         (itr),
      .in_underrun (in_underrun),
      .out_overrun (out_overrun),
      .addr_err    (addr_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      src_valid = '0;
      req_in    = 1'b0;
      out_en    = 1'b0;
      snk_ready = '0;
   endtask

   task automatic test_reset();
      src_data = '0; io_out = '0; addr_in = '0; addr_out = '0;
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      settle();
      checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL reset_src_ready: got %b expected 111", src_ready); end
      checks++; if (snk_valid !== 3'b000) begin errors++; $display("FAIL reset_snk_valid: got %b expected 000", snk_valid); end
      checks++; if ({itr, in_underrun, out_overrun, addr_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {itr, in_underrun, out_overrun, addr_err}); end
      checks++; if (io_in !== '0) begin errors++; $display("FAIL reset_io_in: got %h expected 0", io_in); end
   endtask

   task automatic test_input_read();
      src_data[1*W +: W] = 23'h12345;
      src_valid = 3'b010;
      step();
      src_valid = '0;
      settle();
      checks++; if (src_ready !== 3'b101) begin errors++; $display("FAIL load_ready: got %b expected 101", src_ready); end
      checks++; if (itr !== 1'b0) begin errors++; $display("FAIL itr_latency: got %b expected 0", itr); end
      step();
      settle();
      checks++; if (itr !== 1'b1) begin errors++; $display("FAIL itr_set: got %b expected 1", itr); end
      addr_in = 2'd1; req_in = 1'b1;
      rd_q.push_back(23'h12345);
      settle();
      checks++; if (io_in !== rd_q.pop_front()) begin errors++; $display("FAIL read_same_cycle: got %h expected 12345", io_in); end
      step();
      req_in = 1'b0;
      settle();
      checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL read_empties: got %b expected 111", src_ready); end
      checks++; if (in_underrun !== 1'b0) begin errors++; $display("FAIL read_no_underrun: got %b expected 0", in_underrun); end
      step();
      settle();
      checks++; if (itr !== 1'b0) begin errors++; $display("FAIL itr_clear: got %b expected 0", itr); end
   endtask

   task automatic test_underrun();
      addr_in = 2'd0; req_in = 1'b1;
      settle();
      checks++; if (io_in !== '0) begin errors++; $display("FAIL underrun_io_in: got %h expected 0", io_in); end
      step();
      req_in = 1'b0;
      settle();
      checks++; if (in_underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got %b expected 1", in_underrun); end
      checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL underrun_ready: got %b expected 111", src_ready); end
      step();
      settle();
      checks++; if (in_underrun !== 1'b0) begin errors++; $display("FAIL underrun_width: got %b expected 0", in_underrun); end
   endtask

   task automatic test_overrun();
      addr_out = 2'd0; io_out = 23'h0AAAA; out_en = 1'b1; snk_ready = '0;
      snk_q0.push_back(23'h0AAAA);
      step();
      out_en = 1'b0;
      settle();
      checks++; if (snk_valid[0] !== 1'b1) begin errors++; $display("FAIL write_valid: got %b expected 1", snk_valid[0]); end
      checks++; if (snk_data[0 +: W] !== 23'h0AAAA) begin errors++; $display("FAIL write_data: got %h expected 0aaaa", snk_data[0 +: W]); end
      io_out = 23'h05555; out_en = 1'b1;
      void'(snk_q0.pop_back());
      snk_q0.push_back(23'h05555);
      step();
      out_en = 1'b0;
      settle();
      checks++; if (snk_data[0 +: W] !== 23'h05555) begin errors++; $display("FAIL overwrite_data: got %h expected 05555", snk_data[0 +: W]); end
      checks++; if (out_overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b expected 1", out_overrun); end
      step();
      settle();
      checks++; if (out_overrun !== 1'b0) begin errors++; $display("FAIL overrun_width: got %b expected 0", out_overrun); end
   endtask

   task automatic test_write_during_drain();
      snk_ready = 3'b001; io_out = 23'h00777; out_en = 1'b1;
      settle();
      checks++; if (snk_data[0 +: W] !== snk_q0.pop_front()) begin errors++; $display("FAIL drain_old_word: got %h expected 05555", snk_data[0 +: W]); end
      snk_q0.push_back(23'h00777);
      step();
      out_en = 1'b0; snk_ready = '0;
      settle();
      checks++; if (snk_valid[0] !== 1'b1) begin errors++; $display("FAIL drain_write_valid: got %b expected 1", snk_valid[0]); end
      checks++; if (snk_data[0 +: W] !== 23'h00777) begin errors++; $display("FAIL drain_write_data: got %h expected 00777", snk_data[0 +: W]); end
      checks++; if (out_overrun !== 1'b0) begin errors++; $display("FAIL drain_write_overrun: got %b expected 0", out_overrun); end
      snk_ready = 3'b001;
      settle();
      checks++; if (snk_data[0 +: W] !== snk_q0.pop_front()) begin errors++; $display("FAIL final_drain_data: got %h expected 00777", snk_data[0 +: W]); end
      step();
      snk_ready = '0;
      settle();
      checks++; if (snk_valid[0] !== 1'b0) begin errors++; $display("FAIL final_drain_empty: got %b expected 0", snk_valid[0]); end
   endtask

   task automatic test_back_to_back();
      int handshakes = 0;
      snk_ready = 3'b010; addr_out = 2'd1;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            out_en = 1'b1;
            io_out = W'(23'h40000 + k * 23'h111);
         end else begin
            out_en = 1'b0;
         end
         settle();
         if (snk_valid[1]) begin
            handshakes++;
            checks++;
            if (snk_q1.size() == 0) begin errors++; $display("FAIL b2b_extra_word: got %h expected none", snk_data[1*W +: W]); end
            else if (snk_data[1*W +: W] !== snk_q1[0]) begin errors++; $display("FAIL b2b_data: got %h expected %h", snk_data[1*W +: W], snk_q1[0]); end
            if (snk_q1.size() != 0) void'(snk_q1.pop_front());
         end
         checks++; if (out_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", out_overrun); end
         if (k < 4) snk_q1.push_back(io_out);
         step();
      end
      idle_inputs();
      settle();
      checks++; if (handshakes != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", handshakes); end
      checks++; if (snk_valid[1] !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", snk_valid[1]); end
   endtask

   task automatic test_addr_err();
      addr_in = 2'd3; req_in = 1'b1;
      settle();
      checks++; if (io_in !== '0) begin errors++; $display("FAIL bad_rd_io_in: got %h expected 0", io_in); end
      step();
      settle();
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL bad_rd_pulse1: got %b expected 1", addr_err); end
      checks++; if (in_underrun !== 1'b0) begin errors++; $display("FAIL bad_rd_underrun: got %b expected 0", in_underrun); end
      step();
      req_in = 1'b0;
      settle();
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL bad_rd_pulse2: got %b expected 1", addr_err); end
      step();
      settle();
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL bad_rd_width: got %b expected 0", addr_err); end
      addr_out = 2'd3; io_out = 23'h11111; out_en = 1'b1;
      step();
      out_en = 1'b0;
      settle();
      checks++; if (snk_valid !== 3'b000) begin errors++; $display("FAIL bad_wr_dropped: got %b expected 000", snk_valid); end
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL bad_wr_pulse: got %b expected 1", addr_err); end
      step();
      settle();
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL bad_wr_width: got %b expected 0", addr_err); end
   endtask

   task automatic test_reset_in_flight();
      src_data[0 +: W] = 23'h3CAFE; src_valid = 3'b001;
      addr_out = 2'd1; io_out = 23'h0BEEF; out_en = 1'b1;
      step();
      idle_inputs();
      settle();
      checks++; if ({src_ready[0], snk_valid[1]} !== 2'b01) begin errors++; $display("FAIL pre_reset_state: got %b expected 01", {src_ready[0], snk_valid[1]}); end
      rst = 1'b1;
      addr_in = 2'd2; req_in = 1'b1;
      addr_out = 2'd1; io_out = 23'h01234; out_en = 1'b1;
      step();
      rst = 1'b0;
      idle_inputs();
      addr_in = 2'd0;
      settle();
      checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL rst_src_ready: got %b expected 111", src_ready); end
      checks++; if (snk_valid !== 3'b000) begin errors++; $display("FAIL rst_snk_valid: got %b expected 000", snk_valid); end
      checks++; if ({itr, in_underrun, out_overrun, addr_err} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b expected 0000", {itr, in_underrun, out_overrun, addr_err}); end
      checks++; if (io_in !== '0) begin errors++; $display("FAIL rst_data_cleared: got %h expected 0", io_in); end
      step();
      settle();
      checks++; if ({itr, in_underrun, out_overrun, addr_err} !== 4'b0) begin errors++; $display("FAIL rst_flags_after: got %b expected 0000", {itr, in_underrun, out_overrun, addr_err}); end
   endtask

   initial begin
      test_reset();
      test_input_read();
      test_underrun();
      test_overrun();
      test_write_during_drain();
      test_back_to_back();
      test_addr_err();
      test_reset_in_flight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
